// File: rtl/huffman_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | huffman_pkg : shared constants and types for the Huffman decoder    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package huffman_pkg;

  localparam int NSYM = 6;
  localparam int CW   = 8;
  localparam int LENW = $clog2(CW) + 1;
  localparam int CWB  = $clog2(CW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef logic [2:0] sym_idx_t;

endpackage : huffman_pkg
`default_nettype wire

// File: rtl/huffman_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | huffman_decoder_if : table load, bit stream and symbol handshakes   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface huffman_decoder_if;
  import huffman_pkg::*;

  logic           tbl_we;
  logic [2:0]     tbl_idx;
  logic [CW-1:0]  tbl_code;
  logic [CW-1:0]  tbl_mask;
  logic           start;
  logic           bit_valid;
  logic           bit_in;
  logic           bit_ready;
  logic           sym_valid;
  sym_idx_t       sym_out;
  logic           sym_ready;
  logic           err;
  logic           busy;

  modport master (
    output tbl_we, tbl_idx, tbl_code, tbl_mask, start, bit_valid, bit_in, sym_ready,
    input  bit_ready, sym_valid, sym_out, err, busy
  );

  modport slave (
    input  tbl_we, tbl_idx, tbl_code, tbl_mask, start, bit_valid, bit_in, sym_ready,
    output bit_ready, sym_valid, sym_out, err, busy
  );

endinterface : huffman_decoder_if
`default_nettype wire

// File: rtl/huffman_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | huffman_match : combinational codeword lookup, lowest index wins    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module huffman_match
  import huffman_pkg::*;
(
  input  logic [CW-1:0]            i_acc,
  input  logic [LENW-1:0]          i_len,
  input  logic [NSYM-1:0][CW-1:0]  i_code,
  input  logic [NSYM-1:0][CW-1:0]  i_mask,
  output logic                     o_hit,
  output sym_idx_t                 o_idx
);

  logic [CW-1:0] w_rxmask;

  always_comb begin
    w_rxmask = '0;
    for (int b = 0; b < CW; b++) begin
      w_rxmask[b] = (b < int'(i_len));
    end
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if ((i_len != '0) && (i_mask[i] == w_rxmask) &&
          ((i_acc & w_rxmask) == i_code[i])) begin
        o_hit = 1'b1;
        o_idx = sym_idx_t'(i + 1);
      end
    end
  end

endmodule : huffman_match
`default_nettype wire

// File: rtl/huffman_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | huffman_decoder : bit-serial LSB-first Huffman decoder, 6 symbols   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  huffman_decoder_if.slave  bus
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NSYM-1:0][CW-1:0] r_code;
  logic [NSYM-1:0][CW-1:0] r_mask;
  logic [CW-1:0]           r_acc;
  logic [CW-1:0]           w_acc_d;
  logic [CW-1:0]           w_acc_bit;
  logic [LENW-1:0]         r_len;
  logic [LENW-1:0]         w_len_d;
  logic [LENW-1:0]         w_len_bit;
  logic                    r_sym_valid;
  logic                    w_sym_valid_d;
  sym_idx_t                r_sym_out;
  sym_idx_t                w_sym_out_d;
  logic                    r_err;
  logic                    w_err_d;
  logic                    w_tbl_wr;
  logic                    w_hit;
  sym_idx_t                w_hit_idx;

  always_comb begin
    w_acc_bit = r_acc;
    w_acc_bit[r_len[CWB-1:0]] = bus.bit_in;
    w_len_bit = r_len + LENW'(1);
  end

  huffman_match u_match (
    .i_acc  (w_acc_bit),
    .i_len  (w_len_bit),
    .i_code (r_code),
    .i_mask (r_mask),
    .o_hit  (w_hit),
    .o_idx  (w_hit_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_len       <= '0;
      r_sym_valid <= 1'b0;
      r_sym_out   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_d;
      r_len       <= w_len_d;
      r_sym_valid <= w_sym_valid_d;
      r_sym_out   <= w_sym_out_d;
      r_err       <= w_err_d;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_d       = r_acc;
    w_len_d       = r_len;
    w_sym_valid_d = r_sym_valid;
    w_sym_out_d   = r_sym_out;
    w_err_d       = r_err;
    w_tbl_wr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_tbl_wr = bus.tbl_we;
        if (bus.start) begin
          w_acc_d     = '0;
          w_len_d     = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.bit_valid) begin
          w_acc_d = w_acc_bit;
          w_len_d = w_len_bit;
          // A match on the final permitted bit beats the overflow error.
          if (w_hit) begin
            w_sym_out_d   = w_hit_idx;
            w_sym_valid_d = 1'b1;
            w_state_nxt   = HOLD;
          end else if (w_len_bit == LENW'(CW)) begin
            w_err_d     = 1'b1;
            w_state_nxt = ERR;
          end
        end
      end
      HOLD: begin
        if (bus.sym_ready) begin
          w_sym_valid_d = 1'b0;
          w_acc_d       = '0;
          w_len_d       = '0;
          w_state_nxt   = RUN;
        end
      end
      ERR: begin
        if (bus.start) begin
          w_err_d     = 1'b0;
          w_acc_d     = '0;
          w_len_d     = '0;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Indices 0 and 7 fall outside 1..NSYM and simply never select an entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code <= '0;
      r_mask <= '0;
    end else if (w_tbl_wr) begin
      for (int i = 0; i < NSYM; i++) begin
        if (bus.tbl_idx == 3'(i + 1)) begin
          r_code[i] <= bus.tbl_code;
          r_mask[i] <= bus.tbl_mask;
        end
      end
    end
  end

  assign bus.bit_ready = (r_state == RUN);
  assign bus.busy      = (r_state != IDLE);
  assign bus.sym_valid = r_sym_valid;
  assign bus.sym_out   = r_sym_out;
  assign bus.err       = r_err;

endmodule : huffman_decoder
`default_nettype wire

// File: tb/tb_huffman_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_huffman_decoder : directed self-checking bench for the decoder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_huffman_decoder;
  import huffman_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  huffman_decoder_if bus ();

  huffman_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_entry(input logic [2:0] idx, input logic [7:0] code, input logic [7:0] mask);
    bus.tbl_we   = 1'b1;
    bus.tbl_idx  = idx;
    bus.tbl_code = code;
    bus.tbl_mask = mask;
    tick();
    bus.tbl_we   = 1'b0;
  endtask

  task automatic load_full();
    wr_entry(3'd1, 8'h01, 8'h01);
    wr_entry(3'd2, 8'h02, 8'h03);
    wr_entry(3'd3, 8'h04, 8'h07);
    wr_entry(3'd4, 8'h08, 8'h0F);
    wr_entry(3'd5, 8'h10, 8'h1F);
    wr_entry(3'd6, 8'h00, 8'h1F);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
  endtask

  task automatic release_sym();
    bus.sym_ready = 1'b1;
    tick();
    bus.sym_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.tbl_we = 1'b0;
    bus.tbl_idx = '0;
    bus.tbl_code = '0;
    bus.tbl_mask = '0;
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    bus.sym_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_sym_valid", int'(bus.sym_valid), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_bit_ready", int'(bus.bit_ready), 0);
    check("rst_sym_out", int'(bus.sym_out), 0);
    tick();
    check("idle_busy", int'(bus.busy), 0);

    // Cleared table: no entry can match, so 8 bits must end in an error.
    pulse_start();
    check("start_bit_ready", int'(bus.bit_ready), 1);
    check("start_busy", int'(bus.busy), 1);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    check("clr_tbl_err", int'(bus.err), 1);
    check("clr_tbl_sym_valid", int'(bus.sym_valid), 0);
    check("clr_tbl_bit_ready", int'(bus.bit_ready), 0);
    pulse_reset();
    check("rst2_err", int'(bus.err), 0);
    check("rst2_busy", int'(bus.busy), 0);

    // Single one-bit codeword.
    load_full();
    pulse_start();
    send_bit(1'b1);
    check("one_sym_valid", int'(bus.sym_valid), 1);
    check("one_sym_out", int'(bus.sym_out), 1);
    check("one_bit_ready", int'(bus.bit_ready), 0);
    release_sym();
    check("one_rel_valid", int'(bus.sym_valid), 0);
    check("one_rel_ready", int'(bus.bit_ready), 1);

    // Back-to-back symbols with sink stalls.
    send_bit(1'b0);
    check("b2b_s2_early", int'(bus.sym_valid), 0);
    send_bit(1'b1);
    check("b2b_s2_valid", int'(bus.sym_valid), 1);
    check("b2b_s2_out", int'(bus.sym_out), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall2_valid", int'(bus.sym_valid), 1);
      check("stall2_out", int'(bus.sym_out), 2);
      check("stall2_ready", int'(bus.bit_ready), 0);
    end
    release_sym();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    check("b2b_s6_4bits", int'(bus.sym_valid), 0);
    send_bit(1'b0);
    check("b2b_s6_valid", int'(bus.sym_valid), 1);
    check("b2b_s6_out", int'(bus.sym_out), 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall6_valid", int'(bus.sym_valid), 1);
      check("stall6_out", int'(bus.sym_out), 6);
      check("stall6_ready", int'(bus.bit_ready), 0);
    end
    release_sym();
    check("b2b_rel_valid", int'(bus.sym_valid), 0);

    // Error path with a one-entry table.
    pulse_reset();
    wr_entry(3'd1, 8'h01, 8'h01);
    pulse_start();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("err_7bits", int'(bus.err), 0);
    send_bit(1'b0);
    check("err_8bits", int'(bus.err), 1);
    check("err_bit_ready", int'(bus.bit_ready), 0);
    check("err_busy", int'(bus.busy), 1);
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    tick();
    tick();
    check("err_held_err", int'(bus.err), 1);
    check("err_held_valid", int'(bus.sym_valid), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("err_restart_err", int'(bus.err), 0);
    check("err_restart_ready", int'(bus.bit_ready), 1);
    tick();
    bus.bit_valid = 1'b0;
    check("err_recover_valid", int'(bus.sym_valid), 1);
    check("err_recover_out", int'(bus.sym_out), 1);
    release_sym();

    // Ignored writes: idx 7/0 in IDLE, any write in RUN.
    pulse_reset();
    load_full();
    wr_entry(3'd7, 8'h00, 8'h01);
    wr_entry(3'd0, 8'h00, 8'h01);
    pulse_start();
    wr_entry(3'd3, 8'h00, 8'h01);
    send_bit(1'b0);
    check("ign_bit1", int'(bus.sym_valid), 0);
    send_bit(1'b0);
    check("ign_bit2", int'(bus.sym_valid), 0);
    send_bit(1'b1);
    check("ign_valid", int'(bus.sym_valid), 1);
    check("ign_out", int'(bus.sym_out), 3);
    release_sym();

    // Reset in the middle of a codeword.
    send_bit(1'b0);
    send_bit(1'b0);
    pulse_reset();
    check("mid_busy", int'(bus.busy), 0);
    check("mid_bit_ready", int'(bus.bit_ready), 0);
    check("mid_sym_valid", int'(bus.sym_valid), 0);
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_tbl_cleared", int'(bus.sym_valid), 0);
    pulse_reset();
    load_full();
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_reload_valid", int'(bus.sym_valid), 1);
    check("mid_reload_out", int'(bus.sym_out), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_huffman_decoder
`default_nettype wire

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
Bit-serial Huffman decoder; the receive-side counterpart of the Huffman code-table builder. It holds a 6-entry code table, one (code, mask) pair per symbol, with the same format the builder produces: a code length of L gives mask = 2^L-1, and the code sits in the low L bits. It consumes a codeword stream one bit per handshake and emits one symbol index per completed codeword. It sits between the bitstream source and the symbol sink in the Huffman datapath.

Parameters:
NSYM, 6, number of table entries; symbol indices are 1..NSYM.
CW, 8, maximum codeword length, which is also the code and mask width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
tbl_we  input  1  table write strobe; honoured only in IDLE
tbl_idx  input  3  symbol index to write (1..6)
tbl_code  input  CW  code bits (H) for tbl_idx
tbl_mask  input  CW  mask (M) for tbl_idx; 0 marks the entry unused
start  input  1  leave IDLE or ERR and begin decoding
bit_valid  input  1  stream bit present
bit_in  input  1  stream bit
bit_ready  output  1  decoder accepts a bit this cycle
sym_valid  output  1  sym_out holds a decoded symbol
sym_out  output  3  decoded symbol index (1..6)
sym_ready  input  1  sink accepts the symbol
err  output  1  no codeword matched within CW bits
busy  output  1  state is not IDLE

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. On reset:
  - all table codes and masks clear to 0; acc = 0; len = 0; state = IDLE;
  - sym_valid = 0, sym_out = 0, err = 0, busy = 0, bit_ready = 0.
  - Reset overrides every other input, including mid-codeword and in HOLD.
- Bit order: LSB-first, i.e. root-level bit first. The k-th accepted bit of a codeword (k from 0) is written to acc[k].
- Internal registers: acc[CW-1:0], len[3:0], a table of NSYM x (code, mask).
- States:
  - IDLE: bit_ready = 0.
    - tbl_we with tbl_idx in 1..6 writes that entry. tbl_idx 0 or 7 is ignored.
    - start: acc = 0, len = 0, go to RUN. If tbl_we and start occur in the same cycle, both take effect.
  - RUN: bit_ready = 1. On bit_valid & bit_ready:
    - acc' = acc with bit_in at position len; len' = len + 1; rxmask = 2^len' - 1.
    - Match entry i when mask_i == rxmask and (acc' & rxmask) == code_i.
    - If there is a match, the next cycle has sym_out = i, sym_valid = 1, state HOLD.
    - Prefix-free tables give at most one match. If several match, the lowest index wins.
    - If there is no match and len' == CW: err = 1, state ERR. A match on the CW-th bit takes priority over the error.
    - Otherwise stay in RUN.
  - HOLD: bit_ready = 0; sym_valid and sym_out stay stable.
    - When sym_ready = 1: sym_valid = 0, acc = 0, len = 0, next state RUN.
    - Maximum throughput is one symbol every L+1 cycles.
  - ERR: bit_ready = 0; err stays high.
    - start clears err, acc and len and goes to RUN. The table is kept.
- Latency: sym_valid rises on the clock edge after the last codeword bit is accepted.
- Ignored inputs:
  - tbl_we outside IDLE.
  - start in RUN or HOLD.
  - bit_valid while bit_ready = 0. The bit is not consumed; the source must hold it.
- Entries with mask 0 never match, because rxmask is always at least 1.
- busy = 1 in RUN, HOLD and ERR.

Decomposition:
- Shared package `huffman_pkg` holds:
  - constants NSYM = 6 and CW = 8;
  - the state enum {IDLE, RUN, HOLD, ERR};
  - a symbol-index type of 3 bits.
- Sub-module `huffman_match`: purely combinational. Inputs are acc', len' and the table; outputs are hit and idx (lowest index on multiple hits). It is shared with the planned table checker.
- The FSM, the acc/len counter and the table registers live in the top module.

Test Plan:
- Reset check: assert reset, then release. Required: sym_valid = err = busy = bit_ready = 0, and every table mask reads 0.
- Single one-bit codeword: load table 1:(0x01,0x01), 2:(0x02,0x03), 3:(0x04,0x07), 4:(0x08,0x0F), 5:(0x10,0x1F), 6:(0x00,0x1F); pulse start; send bit 1. Required: on the next edge sym_valid = 1 and sym_out = 1.
- Back-to-back symbols with sink stall: same table; stream bits 0,1 then 0,0,0,0,0; hold sym_ready = 0 for 3 cycles on each symbol. Required: sym_out = 2, then sym_out = 6; sym_valid stable and bit_ready = 0 during each stall; 5-bit symbol accepted after its 5th bit.
- Error path: table with only 1:(0x01,0x01); send eight 0s. Required: err = 1 after the 8th bit, bit_ready = 0, a further bit_valid is not consumed. Then pulse start: err = 0, and sending 1 yields sym_out = 1.
- Ignored writes: in RUN, write 3:(0x00,0x01), then send 0,0,1. Required: sym_out = 3, table unchanged. In IDLE, a write with tbl_idx = 7 changes nothing.
- Reset mid-operation: reset after 2 bits of a 3-bit codeword. Required: state IDLE, table cleared. Then reload, start, send 0,0,1. Required: sym_out = 3 with no stale bits.
